// File: rtl/pll_supervisor_pkg.sv
// Shared types and default timing for the rPLL lock supervisor.
// Default timing assumes a 27 MHz reference clock.
package pll_supervisor_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } sup_state_e;

  localparam int DEF_RST_CYCLES    = 32;
  localparam int DEF_LOCK_TIMEOUT  = 2700000;
  localparam int DEF_STABLE_CYCLES = 27000;
  localparam int DEF_MAX_RETRIES   = 3;
  localparam int LOSS_CNT_W        = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow level signals crossing into a clock domain.
// Asynchronous active-low reset clears both stages to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences rPLL reset, qualifies LOCK and gates the downstream reset; runs on clkin.
// Define PLL_SUPERVISOR_RETRY_LIMIT_EN to stop in FAIL after MAX_RETRIES consecutive timeouts.
module pll_lock_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic                  clkin,
  input  logic                  rst_n,
  input  logic                  pll_lock,
  output logic                  pll_reset,
  output logic                  sys_rst_n,
  output logic                  locked_ok,
  output logic                  fail,
  output logic [LOSS_CNT_W-1:0] loss_cnt,
  output logic [2:0]            state_dbg
);

  localparam int CNT_W = $clog2(max3(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES)) + 1;

  if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 || MAX_RETRIES < 1) begin : g_bad_params
    $error("pll_lock_supervisor: all timing parameters must be at least 1");
  end

  logic                  lock_s;
  sup_state_e            state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [LOSS_CNT_W-1:0] loss_cnt_nxt;
  logic                  pll_reset_nxt, sys_rst_n_nxt, locked_ok_nxt;

  sync_2ff u_lock_sync (
    .clk   (clkin),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
  logic [RETRY_W-1:0] retry_cnt, retry_cnt_nxt;
  logic               fail_nxt;
`endif

  always_comb begin
    state_nxt    = state;
    loss_cnt_nxt = loss_cnt;
`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
    retry_cnt_nxt = retry_cnt;
`endif
    unique case (state)
      ST_RESET_PLL: if (cnt == CNT_W'(RST_CYCLES - 1)) state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        // Lock seen on the timeout cycle wins over the retry.
        if (lock_s) begin
          state_nxt = ST_STABLE;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
          if (retry_cnt == RETRY_W'(MAX_RETRIES - 1)) begin
            state_nxt = ST_FAIL;
          end else begin
            retry_cnt_nxt = retry_cnt + 1'b1;
            state_nxt     = ST_RESET_PLL;
          end
`else
          state_nxt = ST_RESET_PLL;
`endif
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
        end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          state_nxt = ST_RUN;
`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
          retry_cnt_nxt = '0;
`endif
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_nxt = ST_RESET_PLL;
          if (loss_cnt != {LOSS_CNT_W{1'b1}}) loss_cnt_nxt = loss_cnt + 1'b1;
        end
      end
      ST_FAIL: state_nxt = ST_FAIL;
      default: state_nxt = ST_RESET_PLL;
    endcase

    // Outputs are registered from the next state so they change on the entry edge.
    pll_reset_nxt = (state_nxt == ST_RESET_PLL) || (state_nxt == ST_FAIL);
    sys_rst_n_nxt = (state_nxt == ST_RUN);
    locked_ok_nxt = (state_nxt == ST_RUN);
`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
    fail_nxt = (state_nxt == ST_FAIL);
`endif
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RESET_PLL;
      cnt       <= '0;
      loss_cnt  <= '0;
      pll_reset <= 1'b1;
      sys_rst_n <= 1'b0;
      locked_ok <= 1'b0;
    end else begin
      state     <= state_nxt;
      loss_cnt  <= loss_cnt_nxt;
      pll_reset <= pll_reset_nxt;
      sys_rst_n <= sys_rst_n_nxt;
      locked_ok <= locked_ok_nxt;
      // Counter only runs in the timed states and restarts on every transition.
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (state == ST_RESET_PLL || state == ST_WAIT_LOCK || state == ST_STABLE) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= '0;
      fail      <= 1'b0;
    end else begin
      retry_cnt <= retry_cnt_nxt;
      fail      <= fail_nxt;
    end
  end
`else
  assign fail = 1'b0;
`endif

  assign state_dbg = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor with short timing parameters.
// Expected event cycles and counts are queued at stimulus time and popped when observed.
module tb_pll_lock_supervisor;

  localparam int RST_C  = 4;
  localparam int TO_C   = 20;
  localparam int STB_C  = 8;
  localparam int RETR_C = 2;

  logic       clkin;
  logic       rst_n;
  logic       pll_lock;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       locked_ok;
  logic       fail;
  logic [7:0] loss_cnt;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int exp_loss = 0;
  logic [31:0] exp_q[$];

  pll_lock_supervisor #(
    .RST_CYCLES    (RST_C),
    .LOCK_TIMEOUT  (TO_C),
    .STABLE_CYCLES (STB_C),
    .MAX_RETRIES   (RETR_C)
  ) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .sys_rst_n (sys_rst_n),
    .locked_ok (locked_ok),
    .fail      (fail),
    .loss_cnt  (loss_cnt),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic apply_reset(input logic lock_v);
    rst_n    = 1'b0;
    pll_lock = lock_v;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    tick();
    checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL reset_pll_reset got %b exp 1", pll_reset); end
    checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL reset_sys_rst_n got %b exp 0", sys_rst_n); end
    checks++; if (locked_ok !== 1'b0) begin errors++; $display("FAIL reset_locked_ok got %b exp 0", locked_ok); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail got %b exp 0", fail); end
    checks++; if (loss_cnt !== 8'd0) begin errors++; $display("FAIL reset_loss_cnt got %0d exp 0", loss_cnt); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
  endtask

  // Constant lock: reset pulse of RST_C, one WAIT_LOCK cycle, then STB_C stable cycles.
  task automatic test_lock_up();
    bit fell = 0, rose = 0;
    int e;
    exp_q.delete();
    apply_reset(1'b1);
    exp_q.push_back(RST_C);
    exp_q.push_back(RST_C + 1 + STB_C);
    for (int i = 1; i <= 60 && !rose; i++) begin
      tick();
      if (!fell && pll_reset === 1'b0) begin
        fell = 1; e = exp_q.pop_front();
        checks++; if (i !== e) begin errors++; $display("FAIL lockup_pll_reset_len got %0d exp %0d", i, e); end
      end
      if (!rose && sys_rst_n === 1'b1) begin
        rose = 1; e = exp_q.pop_front();
        checks++; if (i !== e) begin errors++; $display("FAIL lockup_release_cycle got %0d exp %0d", i, e); end
      end
    end
    if (!rose) begin checks++; errors++; $display("FAIL lockup_timeout got no release exp release"); end
    checks++; if (locked_ok !== 1'b1) begin errors++; $display("FAIL lockup_locked_ok got %b exp 1", locked_ok); end
    checks++; if (loss_cnt !== 8'd0) begin errors++; $display("FAIL lockup_loss_cnt got %0d exp 0", loss_cnt); end
    checks++; if (state_dbg !== 3'd3) begin errors++; $display("FAIL lockup_state got %0d exp 3", state_dbg); end
  endtask

  // Lock stuck low: pll_reset toggles at fixed cycles; with the retry limit it ends in FAIL.
  task automatic test_timeout();
    logic prev = 1'b1;
    int e;
    int period = RST_C + TO_C;
    exp_q.delete();
    apply_reset(1'b0);
    exp_q.push_back(RST_C);
    exp_q.push_back(period);
    exp_q.push_back(period + RST_C);
    exp_q.push_back(2 * period);
`ifndef PLL_SUPERVISOR_RETRY_LIMIT_EN
    exp_q.push_back(2 * period + RST_C);
`endif
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (pll_reset !== prev) begin
        prev = pll_reset;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL timeout_toggle got edge at %0d exp none", i);
        end else begin
          e = exp_q.pop_front();
          if (i !== e) begin errors++; $display("FAIL timeout_toggle got %0d exp %0d", i, e); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_missing got %0d left exp 0", exp_q.size()); end
`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
    checks++; if (fail !== 1'b1) begin errors++; $display("FAIL timeout_fail got %b exp 1", fail); end
    checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL timeout_pll_reset got %b exp 1", pll_reset); end
    checks++; if (state_dbg !== 3'd4) begin errors++; $display("FAIL timeout_state got %0d exp 4", state_dbg); end
`else
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL timeout_fail got %b exp 0", fail); end
    checks++; if (state_dbg !== 3'd1) begin errors++; $display("FAIL timeout_state got %0d exp 1", state_dbg); end
`endif
    checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL timeout_sys_rst_n got %b exp 0", sys_rst_n); end
  endtask

  // Lock drops for 3 cycles during the 5th STABLE cycle; release needs STB_C fresh cycles.
  task automatic test_stable_bounce();
    int drop_at = RST_C + 1 + 4;
    int e;
    bit rose = 0;
    exp_q.delete();
    apply_reset(1'b1);
    exp_q.push_back(drop_at + 3 + 2 + 1 + STB_C);
    for (int i = 1; i <= 60 && !rose; i++) begin
      tick();
      if (i == drop_at) pll_lock = 1'b0;
      if (i == drop_at + 3) pll_lock = 1'b1;
      if (i == drop_at + 4) begin
        checks++; if (state_dbg !== 3'd1) begin errors++; $display("FAIL bounce_state got %0d exp 1", state_dbg); end
      end
      if (i > RST_C && pll_reset !== 1'b0) begin
        checks++; errors++; $display("FAIL bounce_pll_reset got 1 at %0d exp 0", i);
      end
      if (sys_rst_n === 1'b1) begin
        rose = 1; e = exp_q.pop_front();
        checks++; if (i !== e) begin errors++; $display("FAIL bounce_release got %0d exp %0d", i, e); end
      end
    end
    if (!rose) begin checks++; errors++; $display("FAIL bounce_timeout got no release exp release"); end
  endtask

  // Starts in RUN; one-cycle lock drop forces a full re-acquire.
  task automatic test_run_loss();
    int phase = 0;
    int e;
    exp_q.delete();
    exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
    pll_lock = 1'b0;
    exp_q.push_back(3);
    exp_q.push_back(3 + RST_C);
    exp_q.push_back(3 + RST_C + 1 + STB_C);
    for (int i = 1; i <= 60 && phase < 3; i++) begin
      tick();
      if (i == 1) pll_lock = 1'b1;
      if (phase == 0 && sys_rst_n === 1'b0) begin
        phase = 1; e = exp_q.pop_front();
        checks++; if (i !== e) begin errors++; $display("FAIL loss_drop_cycle got %0d exp %0d", i, e); end
        checks++; if (locked_ok !== 1'b0) begin errors++; $display("FAIL loss_locked_ok got %b exp 0", locked_ok); end
        checks++; if (loss_cnt !== exp_loss[7:0]) begin errors++; $display("FAIL loss_cnt got %0d exp %0d", loss_cnt, exp_loss); end
      end else if (phase == 1 && pll_reset === 1'b0) begin
        phase = 2; e = exp_q.pop_front();
        checks++; if (i !== e) begin errors++; $display("FAIL loss_repulse_end got %0d exp %0d", i, e); end
      end else if (phase == 2 && sys_rst_n === 1'b1) begin
        phase = 3; e = exp_q.pop_front();
        checks++; if (i !== e) begin errors++; $display("FAIL loss_rerelease got %0d exp %0d", i, e); end
      end
    end
    if (phase != 3) begin checks++; errors++; $display("FAIL loss_timeout got phase %0d exp 3", phase); end
  endtask

  // Back-to-back lock-loss events drive loss_cnt into saturation.
  task automatic test_back_to_back_saturation();
    int e;
    bit seen;
    exp_q.delete();
    for (int k = 1; k <= 300; k++) begin
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
      exp_q.push_back(exp_loss);
      pll_lock = 1'b0;
      tick();
      pll_lock = 1'b1;
      seen = 0;
      for (int i = 0; i < 6 && !seen; i++) begin
        if (sys_rst_n === 1'b0) seen = 1; else tick();
      end
      if (!seen) begin checks++; errors++; $display("FAIL sat_no_drop got none exp drop at event %0d", k); break; end
      e = exp_q.pop_front();
      checks++; if (loss_cnt !== e[7:0]) begin errors++; $display("FAIL sat_loss_cnt got %0d exp %0d", loss_cnt, e); end
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        tick();
        if (sys_rst_n === 1'b1) seen = 1;
      end
      if (!seen) begin checks++; errors++; $display("FAIL sat_no_release got none exp release at event %0d", k); break; end
    end
    checks++; if (loss_cnt !== 8'd255) begin errors++; $display("FAIL sat_final got %0d exp 255", loss_cnt); end
  endtask

  // Asynchronous reset mid-STABLE clears everything without waiting for a clock edge.
  task automatic test_async_reset();
    int e;
    bit fell = 0;
    exp_q.delete();
    apply_reset(1'b1);
    repeat (RST_C + 4) tick();
    checks++; if (state_dbg !== 3'd2) begin errors++; $display("FAIL areset_pre_state got %0d exp 2", state_dbg); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL areset_pll_reset got %b exp 1", pll_reset); end
    checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL areset_sys_rst_n got %b exp 0", sys_rst_n); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL areset_state got %0d exp 0", state_dbg); end
    checks++; if (loss_cnt !== 8'd0) begin errors++; $display("FAIL areset_loss_cnt got %0d exp 0", loss_cnt); end
    checks++; if (locked_ok !== 1'b0) begin errors++; $display("FAIL areset_locked_ok got %b exp 0", locked_ok); end
    tick();
    rst_n = 1'b1;
    exp_q.push_back(RST_C);
    for (int i = 1; i <= 20 && !fell; i++) begin
      tick();
      if (pll_reset === 1'b0) begin
        fell = 1; e = exp_q.pop_front();
        checks++; if (i !== e) begin errors++; $display("FAIL areset_counter_cleared got %0d exp %0d", i, e); end
      end
    end
    if (!fell) begin checks++; errors++; $display("FAIL areset_timeout got no pll_reset fall exp fall"); end
  endtask

  initial begin
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    test_reset();
    test_lock_up();
    test_timeout();
    test_stable_bounce();
    exp_loss = 0;
    test_run_loss();
    test_back_to_back_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
